thresholding_cfg_loader: RTL and testbench
==========================================

// Module: thresholding_cfg_loader
//
// PURPOSE
// Sequences threshold configuration for the thresholding core. Streams
// C*T threshold words from an AXI-Stream source into the core's write port
// (twe/twa/twd) in channel-major order. Arbitrates that port with a
// single-word host write path, and gates the core's datapath enable (run)
// until a full table has been loaded.
//
// PARAMETERS
// N  4           output precision; thresholds per channel = 2**N-1; index field N bits
// M  16          threshold word width
// C  1           channel count; channel field $clog2(C) bits (absent for C=1)
// localparam A_BITS = $clog2(C)+N   core write-address width
// localparam T      = 2**N-1        thresholds per channel
//
// PORTS
// clk         in   1       clock
// rst         in   1       reset, synchronous, active-high
// start       in   1       pulse: begin a full table load
// busy        out  1       high while in LOAD
// done        out  1       one-cycle pulse when the last word has been issued to the core
// run         out  1       datapath enable for the core; high only in READY
// cfg_tvalid  in   1       threshold stream valid
// cfg_tready  out  1       threshold stream ready
// cfg_tdata   in   M       threshold word
// lw_vld      in   1       host single-write request
// lw_rdy      out  1       host write accepted
// lw_adr      in   A_BITS  host write address {channel, index}
// lw_dat      in   M       host write data
// twe         out  1       core threshold write enable
// twa         out  A_BITS  core write address
// twd         out  M       core write data
//
// BEHAVIOUR
// - States: IDLE (after reset), LOAD, READY.
// - Reset: state=IDLE, counters=0; busy=0, done=0, run=0, twe=0,
//   cfg_tready=0, lw_rdy=0. twa/twd are don't-care while twe=0.
// - IDLE/READY --start--> LOAD: clears channel counter ch and index counter
//   idx to 0; run drops in the cycle after start is sampled.
// - start while in LOAD: ignored; the load is not restarted.
// - LOAD: cfg_tready=1. Each beat (cfg_tvalid & cfg_tready) issues one write.
// - Counters: idx counts 0..T-1; on idx==T-1 it wraps to 0 and ch increments.
// - Last word: beat with ch==C-1 and idx==T-1. Next state is READY; done
//   pulses in the same cycle as that word's twe.
// - Core address: twa = ch*2**N + idx. Index value 2**N-1 is never written
//   by the loader.
// - Write port is registered: twe/twa/twd are valid exactly 1 cycle after
//   the accepting handshake. Back-to-back beats give back-to-back twe.
// - Host path: lw_rdy = (state != LOAD) && !start, combinational.
//   - An accepted host write drives twe=1, twa=lw_adr, twd=lw_dat 1 cycle later.
//   - Host writes do not change state or run.
//   - lw_adr is passed through unchecked; out-of-range writes go to the core as-is.
// - Arbitration: the loader owns the core port throughout LOAD. start beats
//   lw_vld in the same cycle, so that host write is not accepted.
// - The two write sources are mutually exclusive by state, so there is never
//   more than one twe source in a cycle.
// - run = (state == READY), registered. busy = (state == LOAD).
// - cfg_tvalid outside LOAD: not accepted (cfg_tready=0) and no writes issued.
// - rst mid-LOAD: abort to IDLE and clear counters. Any twe pending for the
//   next cycle is suppressed. The next start reloads from ch=0, idx=0.
//
// TESTING
// - N=2,M=8,C=3: start, then 9 words 0x10..0x18 with tvalid held ->
//   twa = 0,1,2,4,5,6,8,9,10; twd in order; done once with last twe; run=1 next cycle.
// - Same config with tvalid toggling every other cycle -> identical twa/twd
//   sequence, twe only after beats, done exactly once.
// - In READY: lw_vld with adr=5, dat=0xAA -> lw_rdy=1; twe,twa=5,twd=0xAA
//   one cycle later; run stays 1.
// - start and lw_vld asserted together in READY -> lw_rdy=0, busy=1, run=0
//   next cycle, no host write issued.
// - rst after 4 beats of a load -> run=0, busy=0, twe=0. A new start with
//   9 words -> addresses again begin at 0.
// - C=1,N=3: start + 7 words -> twa 0..6, done on the 7th; a second start
//   mid-load is ignored.

Source files
------------

// File: rtl/thresholding_cfg_loader.sv
// -----------------------------------------------------------------------------
// thresholding_cfg_loader
//
// Sequences threshold configuration for the thresholding core. A full table of
// C*T threshold words arrives on an AXI-Stream input and is written to the
// core's write port in channel-major order. Outside a table load, a host can
// write single words through the same port. The core's datapath enable (run)
// stays low until a complete table has been loaded.
//
// Parameters
//   N        output precision; T = 2**N-1 thresholds per channel
//   M        threshold word width
//   C        channel count
//   A_BITS   core write-address width, {channel, index}
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   start                        pulse: begin a full table load
//   busy                         high while a table load is in progress
//   done                         one-cycle pulse alongside the last table write
//   run                          core datapath enable, high once a table is loaded
//   cfg_tvalid/cfg_tready/cfg_tdata   threshold word stream
//   lw_vld/lw_rdy/lw_adr/lw_dat       host single-word write
//   twe/twa/twd                  registered core threshold write port
// -----------------------------------------------------------------------------
module thresholding_cfg_loader #(
    parameter  int N      = 4,
    parameter  int M      = 16,
    parameter  int C      = 1,
    localparam int A_BITS = $clog2(C) + N
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              run,

    input  logic              cfg_tvalid,
    output logic              cfg_tready,
    input  logic [M-1:0]      cfg_tdata,

    input  logic              lw_vld,
    output logic              lw_rdy,
    input  logic [A_BITS-1:0] lw_adr,
    input  logic [M-1:0]      lw_dat,

    output logic              twe,
    output logic [A_BITS-1:0] twa,
    output logic [M-1:0]      twd
);

    // A single-channel core has no channel field; keep a 1-bit counter that
    // never leaves zero so the address arithmetic stays uniform.
    localparam int              CH_W     = (C > 1) ? $clog2(C) : 1;
    localparam logic [N-1:0]    IDX_LAST = N'(2**N - 2);
    localparam logic [CH_W-1:0] CH_LAST  = CH_W'(C - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY
    } state_t;

    state_t            state;
    logic [N-1:0]      idx;
    logic [CH_W-1:0]   ch;

    logic              beat;
    logic              host_acc;
    logic [A_BITS-1:0] load_adr;

    // Stream and host handshakes are closed while rst is high so nothing is
    // accepted in a reset cycle.
    assign busy       = (state == LOAD);
    assign cfg_tready = !rst && (state == LOAD);
    // start has priority over a host write presented in the same cycle.
    assign lw_rdy     = !rst && (state != LOAD) && !start;

    assign beat     = cfg_tvalid && cfg_tready;
    assign host_acc = lw_vld && lw_rdy;

    // Channel-major address: index 2**N-1 of each channel is skipped.
    assign load_adr = (A_BITS'(ch) << N) | A_BITS'(idx);

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            ch    <= '0;
            run   <= 1'b0;
            done  <= 1'b0;
            twe   <= 1'b0;
            twa   <= '0;
            twd   <= '0;
        end else begin
            // Pulses default low and are raised only by this cycle's event.
            twe  <= 1'b0;
            done <= 1'b0;

            case (state)
                IDLE, READY: begin
                    if (start) begin
                        state <= LOAD;
                        idx   <= '0;
                        ch    <= '0;
                        run   <= 1'b0;
                    end else if (host_acc) begin
                        // Host address goes to the core unchecked.
                        twe <= 1'b1;
                        twa <= lw_adr;
                        twd <= lw_dat;
                    end
                end

                LOAD: begin
                    // start is ignored here: the load in progress continues.
                    if (beat) begin
                        twe <= 1'b1;
                        twa <= load_adr;
                        twd <= cfg_tdata;
                        if (idx == IDX_LAST) begin
                            idx <= '0;
                            if (ch == CH_LAST) begin
                                ch    <= '0;
                                state <= READY;
                                run   <= 1'b1;
                                done  <= 1'b1;
                            end else begin
                                ch <= ch + 1'b1;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    run   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thresholding_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_thresholding_cfg_loader
//
// Two instances: dut_a (N=2, M=8, C=3) and dut_b (N=3, M=8, C=1). Expected core
// writes are queued when stimulus is driven and popped by a monitor per
// instance whenever twe is seen. Inputs change on the falling edge; outputs
// are sampled on the falling edge (plus #1 for combinational handshakes).
// -----------------------------------------------------------------------------
module tb_thresholding_cfg_loader;

    typedef struct packed {
        logic [3:0] adr;
        logic [7:0] dat;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut_a signals
    logic       start_a = 0, cfg_tvalid_a = 0, lw_vld_a = 0;
    logic [7:0] cfg_tdata_a = 0, lw_dat_a = 0;
    logic [3:0] lw_adr_a = 0;
    logic       busy_a, done_a, run_a, cfg_tready_a, lw_rdy_a, twe_a;
    logic [3:0] twa_a;
    logic [7:0] twd_a;

    // dut_b signals
    logic       start_b = 0, cfg_tvalid_b = 0, lw_vld_b = 0;
    logic [7:0] cfg_tdata_b = 0, lw_dat_b = 0;
    logic [2:0] lw_adr_b = 0;
    logic       busy_b, done_b, run_b, cfg_tready_b, lw_rdy_b, twe_b;
    logic [2:0] twa_b;
    logic [7:0] twd_b;

    thresholding_cfg_loader #(.N(2), .M(8), .C(3)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .run(run_a),
        .cfg_tvalid(cfg_tvalid_a), .cfg_tready(cfg_tready_a), .cfg_tdata(cfg_tdata_a),
        .lw_vld(lw_vld_a), .lw_rdy(lw_rdy_a), .lw_adr(lw_adr_a), .lw_dat(lw_dat_a),
        .twe(twe_a), .twa(twa_a), .twd(twd_a)
    );

    thresholding_cfg_loader #(.N(3), .M(8), .C(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .run(run_b),
        .cfg_tvalid(cfg_tvalid_b), .cfg_tready(cfg_tready_b), .cfg_tdata(cfg_tdata_b),
        .lw_vld(lw_vld_b), .lw_rdy(lw_rdy_b), .lw_adr(lw_adr_b), .lw_dat(lw_dat_b),
        .twe(twe_b), .twa(twa_b), .twd(twd_b)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    int   done_cnt_a = 0;
    int   done_cnt_b = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Scoreboard monitors: every twe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (twe_a === 1'b1) begin
                check("a_twe_expected", 32'(q_a.size() != 0), 32'd1);
                if (q_a.size() != 0) begin
                    e = q_a.pop_front();
                    check("a_twa", 32'(twa_a), 32'(e.adr));
                    check("a_twd", 32'(twd_a), 32'(e.dat));
                    check("a_done", 32'(done_a), 32'(e.done));
                end
            end else begin
                check("a_twe_low", 32'(twe_a), 32'd0);
                check("a_done_no_twe", 32'(done_a), 32'd0);
            end
            if (done_a === 1'b1) done_cnt_a++;

            if (twe_b === 1'b1) begin
                check("b_twe_expected", 32'(q_b.size() != 0), 32'd1);
                if (q_b.size() != 0) begin
                    e = q_b.pop_front();
                    check("b_twa", 32'(twa_b), 32'(e.adr));
                    check("b_twd", 32'(twd_b), 32'(e.dat));
                    check("b_done", 32'(done_b), 32'(e.done));
                end
            end else begin
                check("b_twe_low", 32'(twe_b), 32'd0);
                check("b_done_no_twe", 32'(done_b), 32'd0);
            end
            if (done_b === 1'b1) done_cnt_b++;
        end
    end

    // Full table load into dut_a (T=3, C=3): word i lands at (i/3)*4 + i%3.
    task automatic load_a(input int base, input bit gap);
        int d0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("a_busy_after_start", 32'(busy_a), 32'd1);
        check("a_run_after_start", 32'(run_a), 32'd0);
        #1;
        check("a_tready_load", 32'(cfg_tready_a), 32'd1);
        check("a_lw_rdy_load", 32'(lw_rdy_a), 32'd0);
        d0 = done_cnt_a;
        for (int i = 0; i < 9; i++) begin
            if (gap) begin
                cfg_tvalid_a = 1'b0;
                tick();
            end
            cfg_tvalid_a = 1'b1;
            cfg_tdata_a  = 8'(base + i);
            q_a.push_back('{adr: 4'((i / 3) * 4 + (i % 3)), dat: 8'(base + i), done: (i == 8)});
            tick();
        end
        cfg_tvalid_a = 1'b0;
        // Last word's twe and done are visible now; run rises with them.
        check("a_run_loaded", 32'(run_a), 32'd1);
        check("a_busy_loaded", 32'(busy_a), 32'd0);
        tick();
        check("a_done_once", 32'(done_cnt_a - d0), 32'd1);
        check("a_run_stays", 32'(run_a), 32'd1);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        #1;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_run", 32'(run_a), 32'd0);
        check("rst_twe", 32'(twe_a), 32'd0);
        check("rst_tready", 32'(cfg_tready_a), 32'd0);
        check("rst_lw_rdy", 32'(lw_rdy_a), 32'd0);
        check("rst_b_run", 32'(run_b), 32'd0);
        tick();
        rst    = 1'b0;
        mon_en = 1'b1;
        #1;
        check("idle_lw_rdy", 32'(lw_rdy_a), 32'd1);
        check("idle_tready", 32'(cfg_tready_a), 32'd0);

        // Full load with tvalid held, then with tvalid toggling
        tick();
        load_a(8'h10, 1'b0);
        load_a(8'h10, 1'b1);

        // Host write in READY
        lw_vld_a = 1'b1; lw_adr_a = 4'd5; lw_dat_a = 8'hAA;
        #1;
        check("host_lw_rdy", 32'(lw_rdy_a), 32'd1);
        q_a.push_back('{adr: 4'd5, dat: 8'hAA, done: 1'b0});
        tick();
        lw_vld_a = 1'b0;
        tick();
        check("host_run_kept", 32'(run_a), 32'd1);
        check("host_busy_low", 32'(busy_a), 32'd0);

        // Stream outside LOAD is refused
        cfg_tvalid_a = 1'b1; cfg_tdata_a = 8'hEE;
        #1;
        check("ready_tready_low", 32'(cfg_tready_a), 32'd0);
        tick();
        tick();
        cfg_tvalid_a = 1'b0;

        // start beats a concurrent host write
        start_a = 1'b1;
        lw_vld_a = 1'b1; lw_adr_a = 4'd3; lw_dat_a = 8'h77;
        #1;
        check("arb_lw_rdy", 32'(lw_rdy_a), 32'd0);
        tick();
        start_a = 1'b0;
        check("arb_busy", 32'(busy_a), 32'd1);
        check("arb_run", 32'(run_a), 32'd0);

        // Four beats (host request still held, must stay blocked), then reset
        for (int i = 0; i < 4; i++) begin
            cfg_tvalid_a = 1'b1;
            cfg_tdata_a  = 8'(8'h30 + i);
            q_a.push_back('{adr: 4'((i / 3) * 4 + (i % 3)), dat: 8'(8'h30 + i), done: 1'b0});
            tick();
        end
        lw_vld_a     = 1'b0;
        cfg_tdata_a  = 8'h34;
        rst          = 1'b1;
        #1;
        check("rst_mid_tready", 32'(cfg_tready_a), 32'd0);
        tick();
        rst          = 1'b0;
        cfg_tvalid_a = 1'b0;
        check("rst_mid_run", 32'(run_a), 32'd0);
        check("rst_mid_busy", 32'(busy_a), 32'd0);
        check("rst_mid_twe", 32'(twe_a), 32'd0);
        tick();

        // Reload restarts at address 0
        load_a(8'h40, 1'b0);

        // Out-of-range host address passes through unchanged
        lw_vld_a = 1'b1; lw_adr_a = 4'd15; lw_dat_a = 8'h55;
        q_a.push_back('{adr: 4'd15, dat: 8'h55, done: 1'b0});
        tick();
        lw_vld_a = 1'b0;
        tick();

        // dut_b (C=1, N=3): 7 words, second start mid-load ignored
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("b_busy", 32'(busy_b), 32'd1);
        for (int i = 0; i < 7; i++) begin
            start_b      = (i == 3);
            cfg_tvalid_b = 1'b1;
            cfg_tdata_b  = 8'(8'h60 + i);
            q_b.push_back('{adr: 4'(i), dat: 8'(8'h60 + i), done: (i == 6)});
            tick();
            if (i == 3) check("b_busy_restart_ignored", 32'(busy_b), 32'd1);
        end
        start_b      = 1'b0;
        cfg_tvalid_b = 1'b0;
        check("b_run", 32'(run_b), 32'd1);
        tick();
        check("b_done_once", 32'(done_cnt_b), 32'd1);
        check("b_busy_end", 32'(busy_b), 32'd0);

        tick();
        tick();
        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
